text_cell_buffer: RTL and testbench



---
 rtl/text_pkg.sv | 33 +++
 rtl/text_cell_ram.sv | 27 ++
 rtl/text_cell_buffer.sv | 166 ++++++++++++++++
 tb/tb_text_cell_buffer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared constants, command encodings and FSM state type for the text cell
// buffer: grid geometry, character width and the pixel-to-cell mapping.
package text_pkg;

  localparam int COLS        = 40;
  localparam int ROWS        = 15;
  localparam int CHAR_W      = 6;
  localparam int CELL_W_LOG2 = 4;
  localparam int CELL_H_LOG2 = 5;

  localparam logic [CHAR_W-1:0] BLANK_CODE = '0;

  localparam int CELLS  = COLS * ROWS;
  localparam int ADDR_W = $clog2(CELLS);
  localparam int PIX_W  = COLS << CELL_W_LOG2;
  localparam int PIX_H  = ROWS << CELL_H_LOG2;

  localparam logic [1:0] CMD_PUT     = 2'b00;
  localparam logic [1:0] CMD_NEWLINE = 2'b01;
  localparam logic [1:0] CMD_CLEAR   = 2'b10;
  localparam logic [1:0] CMD_HOME    = 2'b11;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  // Linear cell address row*COLS+col, computed at 11 bits so no operand is cut.
  function automatic logic [10:0] cell_addr(input logic [4:0] row, input logic [5:0] col);
    return 11'(row) * 11'(COLS) + 11'(col);
  endfunction

endpackage

// File: rtl/text_cell_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old data.
module text_cell_ram #(
  parameter int DEPTH  = 600,
  parameter int WIDTH  = 6,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write and registered read; both non-blocking, so a same-address read sees
  // the value from before this cycle's write.
  // NOTE: the array has no reset -- memories map to RAM macros that cannot be
  // reset; the owner clears it with an explicit sweep instead.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rd_data <= mem[raddr];
  end

endmodule

// File: rtl/text_cell_buffer.sv
// 40x15 character-cell frame store for the VGA text path. Commands arrive on a
// valid/ready port and move a write cursor; each pixel coordinate is mapped to
// its cell and the stored code is returned one cycle later.
// Optional cursor blink: define TEXT_CURSOR_BLINK_EN.
module text_cell_buffer
  import text_pkg::*;
(
  input  logic              VGA_clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [1:0]        wr_cmd,
  input  logic [CHAR_W-1:0] wr_char,
  input  logic [9:0]        xPixel,
  input  logic [9:0]        yPixel,
  input  logic              VGA_vSync,
  output logic [CHAR_W-1:0] char_code,
  output logic [5:0]        cursor_col,
  output logic [3:0]        cursor_row,
  output logic              busy,
  output logic              cursor_hit
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic [5:0]        col_q, col_d;
  logic [3:0]        row_q, row_d;
  logic [3:0]        row_inc;
  logic              in_range_q;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [CHAR_W-1:0] ram_wdata;
  logic [ADDR_W-1:0] ram_raddr;
  logic [CHAR_W-1:0] ram_rdata;

  logic [5:0] pix_col;
  logic [4:0] pix_row;
  logic       pix_in_range;

  assign pix_col      = xPixel[9:CELL_W_LOG2];
  assign pix_row      = yPixel[9:CELL_H_LOG2];
  assign pix_in_range = (xPixel < 10'(PIX_W)) && (yPixel < 10'(PIX_H));
  assign ram_raddr    = pix_in_range ? ADDR_W'(cell_addr(pix_row, pix_col)) : '0;

  // Next row with wrap at the bottom; the grid never scrolls.
  assign row_inc = (row_q == 4'(ROWS - 1)) ? 4'd0 : row_q + 4'd1;

  // Sweep / command FSM: next state, cursor update and write-port steering.
  // NOTE: every output is given a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    col_d     = col_q;
    row_d     = row_q;
    ram_we    = 1'b0;
    ram_waddr = ADDR_W'(cell_addr(5'(row_q), col_q));
    ram_wdata = wr_char;
    wr_ready  = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        busy      = 1'b1;
        ram_we    = 1'b1;
        ram_waddr = sweep_q;
        ram_wdata = BLANK_CODE;
        if (sweep_q == ADDR_W'(CELLS - 1)) state_d = ST_IDLE;
        else                               sweep_d = sweep_q + 1'b1;
      end
      ST_IDLE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          case (wr_cmd)
            CMD_PUT: begin
              ram_we = 1'b1;
              if (col_q == 6'(COLS - 1)) begin
                col_d = '0;
                row_d = row_inc;
              end else begin
                col_d = col_q + 6'd1;
              end
            end
            CMD_NEWLINE: begin
              col_d = '0;
              row_d = row_inc;
            end
            CMD_CLEAR: begin
              col_d   = '0;
              row_d   = '0;
              sweep_d = '0;
              state_d = ST_CLEAR;
            end
            default: begin
              col_d = '0;
              row_d = '0;
            end
          endcase
        end
      end
      default: state_d = ST_CLEAR;
    endcase
    if (reset) ram_we = 1'b0;
  end

  // State, sweep pointer, cursor and read-range registers; reset restarts the sweep.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      sweep_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      in_range_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      col_q      <= col_d;
      row_q      <= row_d;
      in_range_q <= pix_in_range;
    end
  end

  text_cell_ram #(
    .DEPTH (CELLS),
    .WIDTH (CHAR_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (VGA_clk),
    .we     (ram_we),
    .waddr  (ram_waddr),
    .wdata  (ram_wdata),
    .raddr  (ram_raddr),
    .rd_data(ram_rdata)
  );

  assign char_code  = in_range_q ? ram_rdata : BLANK_CODE;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

`ifdef TEXT_CURSOR_BLINK_EN
  logic       vsync_q;
  logic [4:0] frame_cnt;
  logic       hit_q;

  // Frame counter on synchronously detected vSync falls, plus the cursor-cell
  // match registered alongside char_code.
  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      vsync_q   <= 1'b1;
      frame_cnt <= '0;
      hit_q     <= 1'b0;
    end else begin
      vsync_q <= VGA_vSync;
      if (vsync_q && !VGA_vSync) frame_cnt <= frame_cnt + 5'd1;
      hit_q <= pix_in_range && (pix_col == col_q) && (pix_row == 5'(row_q)) && frame_cnt[4];
    end
  end

  assign cursor_hit = hit_q;
`else
  logic unused_vsync;
  assign unused_vsync = VGA_vSync;
  assign cursor_hit   = 1'b0;
`endif

endmodule

// File: tb/tb_text_cell_buffer.sv
// Directed self-checking bench for text_cell_buffer. Inputs change on the
// falling edge; outputs are sampled on the falling edge after the active edge.
module tb_text_cell_buffer;

  localparam logic [1:0] PUT = 2'b00, NL = 2'b01, CLR = 2'b10, HOME = 2'b11;
`ifdef TEXT_CURSOR_BLINK_EN
  localparam logic BLINK = 1'b1;
`else
  localparam logic BLINK = 1'b0;
`endif

  logic       VGA_clk = 1'b0;
  logic       reset, wr_valid, wr_ready, VGA_vSync, busy, cursor_hit;
  logic [1:0] wr_cmd;
  logic [5:0] wr_char, char_code, cursor_col;
  logic [9:0] xPixel, yPixel;
  logic [3:0] cursor_row;

  int vectors = 0;
  int errors  = 0;

  text_cell_buffer dut (
    .VGA_clk   (VGA_clk),
    .reset     (reset),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_cmd    (wr_cmd),
    .wr_char   (wr_char),
    .xPixel    (xPixel),
    .yPixel    (yPixel),
    .VGA_vSync (VGA_vSync),
    .char_code (char_code),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row),
    .busy      (busy),
    .cursor_hit(cursor_hit)
  );

  always #20 VGA_clk = ~VGA_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge VGA_clk);
    @(negedge VGA_clk);
  endtask

  task automatic send(input logic [1:0] cmd, input logic [5:0] ch);
    wr_valid = 1'b1;
    wr_cmd   = cmd;
    wr_char  = ch;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic read_cell(input string tag, input int x, input int y, input logic [5:0] exp);
    xPixel = 10'(x);
    yPixel = 10'(y);
    tick();
    check(tag, char_code, exp);
  endtask

  task automatic check_cursor(input string tag, input int col, input int row);
    check({tag, "_col"}, cursor_col, col);
    check({tag, "_row"}, cursor_row, row);
  endtask

  // Counts cycles with busy high from the current falling edge, bounded.
  task automatic wait_sweep(input string tag);
    int   n = 0;
    logic ready_seen = 1'b0;
    while (busy === 1'b1 && n < 2000) begin
      if (wr_ready !== 1'b0) ready_seen = 1'b1;
      n++;
      tick();
    end
    check({tag, "_busy_cycles"}, n, 600);
    check({tag, "_ready_low"}, ready_seen, 1'b0);
  endtask

  task automatic vsync_falls(input int n);
    for (int i = 0; i < n; i++) begin
      VGA_vSync = 1'b0;
      tick();
      VGA_vSync = 1'b1;
      tick();
    end
  endtask

  initial begin
    reset     = 1'b1;
    wr_valid  = 1'b0;
    wr_cmd    = PUT;
    wr_char   = '0;
    xPixel    = '0;
    yPixel    = '0;
    VGA_vSync = 1'b1;
    repeat (2) @(posedge VGA_clk);
    @(negedge VGA_clk);

    // Reset state
    check("rst_busy", busy, 1'b1);
    check("rst_ready", wr_ready, 1'b0);
    check("rst_char", char_code, 6'h00);
    check("rst_hit", cursor_hit, 1'b0);
    check_cursor("rst_cursor", 0, 0);

    // Power-up sweep
    reset = 1'b0;
    wait_sweep("init");
    check("init_ready", wr_ready, 1'b1);
    check("init_busy", busy, 1'b0);
    check_cursor("init_cursor", 0, 0);
    read_cell("init_blank", 80, 160, 6'h00);

    // First PUT and readback
    send(PUT, 6'h05);
    check_cursor("put1", 1, 0);
    read_cell("put1_read", 3, 10, 6'h05);

    // Row 14, then 40 PUTs wrap the cursor to the top
    for (int i = 0; i < 14; i++) send(NL, 6'h00);
    check_cursor("nl14", 0, 14);
    for (int i = 0; i < 40; i++) send(PUT, 6'(10 + i));
    check_cursor("wrap", 0, 0);
    read_cell("last_cell", 624, 448, 6'd49);
    read_cell("row14_first", 0, 448, 6'd10);
    read_cell("wrap_no_write", 3, 10, 6'h05);

    // NEWLINE from (17,2), then HOME
    send(NL, 6'h00);
    send(NL, 6'h00);
    for (int i = 0; i < 17; i++) send(PUT, 6'h07);
    check_cursor("at17_2", 17, 2);
    send(NL, 6'h00);
    check_cursor("newline", 0, 3);
    send(HOME, 6'h00);
    check_cursor("home", 0, 0);
    read_cell("home_keep_a", 256, 64, 6'h07);
    read_cell("home_keep_b", 272, 64, 6'h00);
    read_cell("home_keep_c", 3, 10, 6'h05);

    // Visible-area boundaries
    read_cell("edge_in", 639, 479, 6'd49);
    read_cell("x_eq_640", 640, 479, 6'h00);
    read_cell("x_700", 700, 10, 6'h00);
    read_cell("y_500", 3, 500, 6'h00);
    read_cell("y_eq_480", 639, 480, 6'h00);

    // Same-cycle read and write of cell (0,0): old data first
    xPixel   = 10'd0;
    yPixel   = 10'd0;
    send(PUT, 6'h2A);
    check("rbw_old", char_code, 6'h05);
    tick();
    check("rbw_new", char_code, 6'h2A);
    check_cursor("rbw_cursor", 1, 0);

    // Cursor at (2,1); pixel (35,40) is inside that cell
    send(HOME, 6'h00);
    send(NL, 6'h00);
    send(PUT, 6'h01);
    send(PUT, 6'h02);
    check_cursor("blink_pos", 2, 1);
    read_cell("blink_cell", 35, 40, 6'h00);
    check("blink_phase0", cursor_hit, 1'b0);
    vsync_falls(16);
    tick();
    check("blink_phase1", cursor_hit, BLINK);
    vsync_falls(16);
    tick();
    check("blink_phase2", cursor_hit, 1'b0);

    // CLEAR command, ignored writes, then reset mid-sweep
    send(CLR, 6'h00);
    check("clr_ready_drop", wr_ready, 1'b0);
    check("clr_busy", busy, 1'b1);
    check_cursor("clr_cursor", 0, 0);
    wr_valid = 1'b1;
    wr_cmd   = PUT;
    wr_char  = 6'h33;
    repeat (300) tick();
    wr_valid = 1'b0;
    check("mid_busy", busy, 1'b1);
    check_cursor("mid_ignored", 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_sweep("restart");
    check("restart_ready", wr_ready, 1'b1);
    check_cursor("restart_cursor", 0, 0);
    read_cell("clr_a", 3, 10, 6'h00);
    read_cell("clr_b", 624, 448, 6'h00);
    read_cell("clr_c", 256, 64, 6'h00);
    read_cell("clr_d", 35, 40, 6'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
